// File: rtl/rd_adv.sv
// Receive-side data advance: deserialises DAT0 or DAT3:0 samples into bytes,
// optionally hunting for the block start bit first, and acks each byte.
module rd_adv #(
   parameter int HUNT_W = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       data_width,
   input  logic       hunt_start,
   input  logic       bus_req,
   output logic [7:0] bus_dat_o,
   output logic       bus_ack,
   output logic       rd_timeout,
   input  logic [3:0] dat_rd,
   output logic       clk_tick,
   input  logic       clk_done,
   input  logic       clk_ack
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HUNT  = 2'd1,
      SHIFT = 2'd2,
      HOLD  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic              dw_q, dw_d;
   logic [7:0]        sr_q, sr_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic [HUNT_W-1:0] hunt_cnt_q, hunt_cnt_d;
   logic [7:0]        bus_dat_q, bus_dat_d;
   logic              bus_ack_q, bus_ack_d;
   logic              rd_timeout_q, rd_timeout_d;

   logic              start_seen;
   logic              last_sample;
   logic [7:0]        sr_shift;

   always_comb begin
      start_seen  = dw_q ? (dat_rd == 4'h0) : ~dat_rd[0];
      sr_shift    = dw_q ? {sr_q[3:0], dat_rd} : {sr_q[6:0], dat_rd[0]};
      last_sample = dw_q ? (bit_cnt_q == 3'd1) : (bit_cnt_q == 3'd7);
   end

   always_comb begin
      state_d      = state_q;
      dw_d         = dw_q;
      sr_d         = sr_q;
      bit_cnt_d    = bit_cnt_q;
      hunt_cnt_d   = hunt_cnt_q;
      bus_dat_d    = bus_dat_q;
      bus_ack_d    = 1'b0;
      rd_timeout_d = rd_timeout_q;
      clk_tick     = 1'b0;

      case (state_q)
         IDLE: begin
            // Ask for the first edge in the request cycle itself; any clk_ack
            // seen now belongs to nobody and is dropped.
            clk_tick = bus_req;
            if (bus_req) begin
               dw_d         = data_width;
               sr_d         = 8'h00;
               bit_cnt_d    = 3'd0;
               hunt_cnt_d   = '0;
               rd_timeout_d = 1'b0;
               state_d      = hunt_start ? HUNT : SHIFT;
            end
         end
         HUNT: begin
            clk_tick = 1'b1;
            if (clk_ack) begin
               if (start_seen) begin
                  state_d = SHIFT;
               end else if (hunt_cnt_q == {HUNT_W{1'b1}}) begin
                  rd_timeout_d = 1'b1;
                  state_d      = HOLD;
               end else begin
                  hunt_cnt_d = hunt_cnt_q + 1'b1;
               end
            end
         end
         SHIFT: begin
            clk_tick = 1'b1;
            if (clk_ack) begin
               sr_d = sr_shift;
               if (last_sample) begin
                  bus_dat_d = sr_shift;
                  state_d   = HOLD;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end
         HOLD: begin
            // Stop requesting edges and let any in-flight edge drain first.
            if (clk_done) begin
               bus_ack_d = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         dw_q         <= 1'b0;
         sr_q         <= 8'h00;
         bit_cnt_q    <= 3'd0;
         hunt_cnt_q   <= '0;
         bus_dat_q    <= 8'h00;
         bus_ack_q    <= 1'b0;
         rd_timeout_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         dw_q         <= dw_d;
         sr_q         <= sr_d;
         bit_cnt_q    <= bit_cnt_d;
         hunt_cnt_q   <= hunt_cnt_d;
         bus_dat_q    <= bus_dat_d;
         bus_ack_q    <= bus_ack_d;
         rd_timeout_q <= rd_timeout_d;
      end
   end

   assign bus_dat_o  = bus_dat_q;
   assign bus_ack    = bus_ack_q;
   assign rd_timeout = rd_timeout_q;

endmodule

// File: tb/tb_rd_adv.sv
// Directed bench for rd_adv: table of byte transactions plus hand sequences
// for clk_done stalls, async reset, and mid-byte input changes.
module tb_rd_adv;

   logic       clk;
   logic       rst;
   logic       data_width;
   logic       hunt_start;
   logic       bus_req;
   logic [7:0] bus_dat_o;
   logic       bus_ack;
   logic       rd_timeout;
   logic [3:0] dat_rd;
   logic       clk_tick;
   logic       clk_done;
   logic       clk_ack;

   int n_total = 0;
   int n_pass  = 0;

   rd_adv #(.HUNT_W(3)) dut (
      .clk        (clk),
      .rst        (rst),
      .data_width (data_width),
      .hunt_start (hunt_start),
      .bus_req    (bus_req),
      .bus_dat_o  (bus_dat_o),
      .bus_ack    (bus_ack),
      .rd_timeout (rd_timeout),
      .dat_rd     (dat_rd),
      .clk_tick   (clk_tick),
      .clk_done   (clk_done),
      .clk_ack    (clk_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic             dw;
      logic             hunt;
      int               n;
      logic [15:0][3:0] smp;
      logic [7:0]       exp_dat;
      logic             exp_to;
      string            name;
   } vec_t;

   vec_t vec [7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic pulse_req(input logic dw, input logic hs);
      @(posedge clk); #1;
      bus_req    = 1'b1;
      data_width = dw;
      hunt_start = hs;
      @(negedge clk);
      chk("tick_in_req_cycle", {31'd0, clk_tick}, 32'd1);
      @(posedge clk); #1;
      bus_req = 1'b0;
   endtask

   task automatic give_ack(input logic [3:0] d);
      dat_rd  = d;
      clk_ack = 1'b1;
      @(posedge clk); #1;
      clk_ack = 1'b0;
   endtask

   task automatic check_done(input string name, input logic [7:0] ed, input logic et);
      @(negedge clk);
      chk({name, "_hold_noack"}, {31'd0, bus_ack}, 32'd0);
      chk({name, "_hold_tick"}, {31'd0, clk_tick}, 32'd0);
      @(negedge clk);
      chk({name, "_ack"}, {31'd0, bus_ack}, 32'd1);
      chk({name, "_dat"}, {24'd0, bus_dat_o}, {24'd0, ed});
      chk({name, "_timeout"}, {31'd0, rd_timeout}, {31'd0, et});
      @(negedge clk);
      chk({name, "_ack_single"}, {31'd0, bus_ack}, 32'd0);
      $display("txn %s: dat=0x%02h timeout=%0d", name, bus_dat_o, rd_timeout);
   endtask

   initial begin
      int acks;
      rst        = 1'b1;
      data_width = 1'b0;
      hunt_start = 1'b0;
      bus_req    = 1'b0;
      dat_rd     = 4'h0;
      clk_done   = 1'b1;
      clk_ack    = 1'b0;

      vec[0] = '{1'b0, 1'b0, 8,
                 {4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,
                  4'h1,4'h0,4'h1,4'h0,4'h0,4'h1,4'h0,4'h1}, 8'hA5, 1'b0, "dw1_A5"};
      vec[1] = '{1'b1, 1'b1, 5,
                 {4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,
                  4'h0,4'h0,4'h0,4'hC,4'h3,4'h0,4'hF,4'hF}, 8'h3C, 1'b0, "dw4_hunt_3C"};
      vec[2] = '{1'b1, 1'b0, 2,
                 {4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,
                  4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'hE,4'h7}, 8'h7E, 1'b0, "dw4_7E"};
      vec[3] = '{1'b0, 1'b1, 8,
                 {4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,
                  4'h1,4'h1,4'h1,4'h1,4'h1,4'h1,4'h1,4'h1}, 8'h7E, 1'b1, "hunt_timeout"};
      vec[4] = '{1'b0, 1'b1, 16,
                 {4'h1,4'h1,4'h1,4'h1,4'h0,4'h0,4'h0,4'h0,
                  4'h0,4'h1,4'h1,4'h1,4'h1,4'h1,4'h1,4'h1}, 8'h0F, 1'b0, "start_last"};
      vec[5] = '{1'b0, 1'b0, 8,
                 {4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,
                  4'h1,4'h1,4'h0,4'h0,4'h0,4'h0,4'h1,4'h1}, 8'hC3, 1'b0, "dw1_C3"};
      vec[6] = '{1'b0, 1'b0, 8,
                 {4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,
                  4'hF,4'hE,4'hF,4'hE,4'hF,4'hE,4'hF,4'hE}, 8'h55, 1'b0, "dw1_upper_ignored"};

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_dat", {24'd0, bus_dat_o}, 32'd0);
      chk("rst_ack", {31'd0, bus_ack}, 32'd0);
      chk("rst_timeout", {31'd0, rd_timeout}, 32'd0);
      chk("rst_tick", {31'd0, clk_tick}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      for (int i = 0; i < 7; i++) begin
         pulse_req(vec[i].dw, vec[i].hunt);
         for (int j = 0; j < vec[i].n; j++) give_ack(vec[i].smp[j]);
         check_done(vec[i].name, vec[i].exp_dat, vec[i].exp_to);
      end

      // clk_done stall with stray bus_req pulses during SHIFT and HOLD
      clk_done = 1'b0;
      pulse_req(1'b0, 1'b0);
      give_ack(4'h0);
      bus_req = 1'b1;
      give_ack(4'h1);
      bus_req = 1'b0;
      give_ack(4'h1);
      give_ack(4'h0);
      give_ack(4'h1);
      give_ack(4'h0);
      give_ack(4'h0);
      give_ack(4'h1);
      for (int k = 0; k < 5; k++) begin
         bus_req = (k == 2);
         @(negedge clk);
         chk("stall_noack", {31'd0, bus_ack}, 32'd0);
         chk("stall_tick", {31'd0, clk_tick}, 32'd0);
      end
      @(posedge clk); #1;
      bus_req  = 1'b0;
      clk_done = 1'b1;
      @(negedge clk);
      chk("stall_done_cycle_noack", {31'd0, bus_ack}, 32'd0);
      @(negedge clk);
      chk("stall_ack", {31'd0, bus_ack}, 32'd1);
      chk("stall_dat", {24'd0, bus_dat_o}, 32'h69);
      acks = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (bus_ack) acks++;
      end
      chk("stall_no_extra_ack", acks, 32'd0);
      $display("txn stall: dat=0x%02h", bus_dat_o);

      // async reset after 3 bits of a DW_1 byte
      pulse_req(1'b0, 1'b0);
      give_ack(4'h1);
      give_ack(4'h0);
      give_ack(4'h1);
      #2 rst = 1'b1;
      #1;
      chk("arst_dat", {24'd0, bus_dat_o}, 32'd0);
      chk("arst_ack", {31'd0, bus_ack}, 32'd0);
      chk("arst_timeout", {31'd0, rd_timeout}, 32'd0);
      chk("arst_tick", {31'd0, clk_tick}, 32'd0);
      $display("txn async_reset: dat=0x%02h tick=%0d", bus_dat_o, clk_tick);
      @(posedge clk); #1;
      rst = 1'b0;
      pulse_req(1'b0, 1'b0);
      give_ack(4'h1); give_ack(4'h0); give_ack(4'h0); give_ack(4'h1);
      give_ack(4'h0); give_ack(4'h1); give_ack(4'h1); give_ack(4'h0);
      check_done("after_reset_96", 8'h96, 1'b0);

      // same-cycle clk_ack ignored; width/hunt toggled mid-byte
      @(posedge clk); #1;
      bus_req    = 1'b1;
      data_width = 1'b0;
      hunt_start = 1'b0;
      clk_ack    = 1'b1;
      dat_rd     = 4'h0;
      @(posedge clk); #1;
      bus_req    = 1'b0;
      clk_ack    = 1'b0;
      data_width = 1'b1;
      hunt_start = 1'b1;
      give_ack(4'h1); give_ack(4'h1); give_ack(4'h1); give_ack(4'h1);
      give_ack(4'h0); give_ack(4'h0); give_ack(4'h0); give_ack(4'h1);
      check_done("dw_toggle_F1", 8'hF1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/rd_adv.md
Name: rd_adv

Overview:
- Receive-side data advance for the MMC controller.
- Deserialises card read data from the 1-bit (DAT0) or 4-bit (DAT3:0) bus into bytes, one byte per bus request.
- Requests MMC clock edges from the clock generator via clk_tick. Samples on clk_ack.
- Optionally hunts for the block start bit before the first byte. Returns each assembled byte to the bus side with a single-cycle ack.

Parameters:
- HUNT_W, 10, width of the start-bit hunt counter. Timeout after 2^HUNT_W clk_acks with no start bit.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- data_width  input  1  0 = 1-bit bus (DW_1), 1 = 4-bit bus (DW_4). Sampled on accepted bus_req.
- hunt_start  input  1  qualifies bus_req: hunt for the start bit before shifting this byte. Sampled with bus_req.
- bus_req  input  1  single-cycle pulse requesting one byte.
- bus_dat_o  output  8  last assembled byte, MSB received first.
- bus_ack  output  1  single-cycle pulse: byte (or timeout) complete.
- rd_timeout  output  1  status for the acked request: 1 = start bit not found within 2^HUNT_W samples.
- dat_rd  input  4  card DAT lines; only [0] is used in DW_1.
- clk_tick  output  1  request MMC clock edges while high.
- clk_done  input  1  clock generator idle (no edge pending).
- clk_ack  input  1  single-cycle pulse: MMC edge occurred, dat_rd valid this cycle.

Behaviour:
- Reset (async, immediate, any state): state=IDLE, bus_dat_o=0, bus_ack=0, rd_timeout=0, shift register=0, counters=0, clk_tick=0.
- States: IDLE, HUNT, SHIFT, HOLD.
- IDLE:
  - bus_req latches data_width and hunt_start, clears bit counter and hunt counter, clears rd_timeout.
  - Next state is HUNT if hunt_start=1, else SHIFT.
- clk_tick = bus_req in IDLE, OR state is HUNT or SHIFT (combinational). The first edge is requested in the request cycle with no bubble.
- clk_ack arriving in the same cycle as bus_req is ignored. Sampling starts the cycle after.
- HUNT: on each clk_ack:
  - DW_1: start bit is dat_rd[0]==0. DW_4: start bit is dat_rd==4'h0.
  - Start bit seen -> SHIFT. The start sample is not stored.
  - No start bit -> increment hunt counter. When the counter is at 2^HUNT_W-1 and there is still no start bit, set rd_timeout=1 and go to HOLD. bus_dat_o is unchanged.
  - Start bit on the final allowed sample takes priority over timeout.
- SHIFT: on each clk_ack:
  - DW_1: shift in dat_rd[0] at the LSB, {sr[6:0],dat_rd[0]}. 8 samples.
  - DW_4: shift in the nibble, {sr[3:0],dat_rd}. 2 samples; first nibble becomes [7:4].
  - The bit counter is 3 bits and does not wrap within a byte.
  - On the last sample, load bus_dat_o with the completed value (same edge) and go to HOLD.
- HOLD:
  - clk_tick=0. Wait for clk_done=1, so the generator has drained any edge already in flight.
  - The cycle clk_done is seen high: go to IDLE, and bus_ack=1 for exactly the next cycle (registered).
  - If clk_done is already high on entry, the ack follows one cycle after HOLD entry.
- clk_ack while in IDLE or HOLD: ignored, no state change.
- bus_req while not IDLE: ignored, no queueing. The bus side must wait for bus_ack.
- data_width or hunt_start changing mid-byte: no effect; the latched copies are used.
- bus_dat_o holds its value until the next successful byte completes. rd_timeout holds until the next accepted bus_req.
- Latency with no hunt and clk_done immediate: bus_ack at N+2 cycles after the last clk_ack edge is sampled … precisely: last clk_ack at cycle t -> HOLD at t+1 -> bus_ack at t+2.

Test Plan:
- DW_1, hunt_start=0, bus_req, then 8 clk_acks with DAT0 = 1,0,1,0,0,1,0,1 -> bus_dat_o=8'hA5, one bus_ack pulse, rd_timeout=0, clk_tick low after the 8th ack.
- DW_4, hunt_start=1, dat_rd=F,F,0 (start) then 3,C -> bus_dat_o=8'h3C after 5 clk_acks, bus_ack once. A further bus_req with dat_rd=7,E -> 8'h7E.
- HUNT_W=3, DW_1, hunt_start=1, DAT0 held 1 for 8 clk_acks -> rd_timeout=1, bus_ack pulse, bus_dat_o unchanged. Start bit on the 8th sample instead -> no timeout, SHIFT entered.
- clk_done held low for 5 cycles after the final clk_ack -> bus_ack delayed until 1 cycle after clk_done rises. Extra bus_req pulses during SHIFT/HOLD are ignored (exactly one ack).
- rst asserted asynchronously mid-SHIFT after 3 bits -> all outputs 0 immediately. After release, a new bus_req assembles a full fresh byte (no stale bits).
- data_width toggled after bus_req during a DW_1 byte -> still 8 samples consumed, correct byte assembled.
